// File: rtl/sys1_video_pkg.sv
// Shared palette-stage constants, read-FSM state type and BBGGGRRR -> 15-bit RGB expansion.
package sys1_video_pkg;
   localparam int PAL_AW = 11;
   localparam int PAL_DW = 8;
   localparam int RGB_W  = 15;

   typedef enum logic [1:0] {IDLE, RDPEND, RDDATA} rd_state_t;

   // Replicate the high bits of each field to fill 5 bits: {B5,G5,R5}
   function automatic logic [RGB_W-1:0] pal8_to_rgb15(input logic [PAL_DW-1:0] e);
      return {e[7:6], e[7:6], e[7], e[5:3], e[5:4], e[2:0], e[2:1]};
   endfunction
endpackage

// File: rtl/sys1_palette_if.sv
// Pixel and CPU-side signals of the palette stage; master = mixer/CPU side, slave = palette.
interface sys1_palette_if;
   import sys1_video_pkg::*;

   logic [PAL_AW-1:0] PIDX;
   logic              BLANK;
   logic [RGB_W-1:0]  ORGB;
   logic [PAL_AW-1:0] CPUAD;
   logic [PAL_DW-1:0] CPUDI;
   logic              CPUWR;
   logic              CPURD;
   logic [PAL_DW-1:0] CPUDO;
   logic              CPURDY;
   logic              CPUWAIT;

   modport master (
      output PIDX, BLANK, CPUAD, CPUDI, CPUWR, CPURD,
      input  ORGB, CPUDO, CPURDY, CPUWAIT
   );

   modport slave (
      input  PIDX, BLANK, CPUAD, CPUDI, CPUWR, CPURD,
      output ORGB, CPUDO, CPURDY, CPUWAIT
   );
endinterface

// File: rtl/sys1_palram.sv
// 2048x8 single-port synchronous palette RAM, 1-cycle read; read data holds on write cycles.
// No reset: contents survive RESET.
module sys1_palram
   import sys1_video_pkg::*;
#(
   parameter int AW = PAL_AW,
   parameter int DW = PAL_DW
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdat,
   output logic [DW-1:0] rdat
);
   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= wdat;
      else
         rdat <= mem[addr];
   end
endmodule

// File: rtl/sys1_palette.sv
// Palette lookup + colour expansion, fixed 2-PCLK video latency; CPU writes/reads use blank slots only.
// Backpressure: CPUWAIT holds the CPU while the single-entry write buffer waits for a blank slot.
module sys1_palette #(
   parameter int PAL_AW = sys1_video_pkg::PAL_AW,
   parameter int PAL_DW = sys1_video_pkg::PAL_DW
) (
   input  logic           PCLK,
   input  logic           RESET,
   sys1_palette_if.slave  bus
);
   import sys1_video_pkg::*;

   logic              wb_full;
   logic [PAL_AW-1:0] wb_ad;
   logic [PAL_DW-1:0] wb_di;
   rd_state_t         state, state_nxt;
   logic              rd_ph;
   logic [PAL_AW-1:0] rd_ad;
   logic              commit, rd_acc, ram_we;
   logic [PAL_AW-1:0] ram_ad;
   logic [PAL_DW-1:0] ram_q, ram_dq;
   logic              blank_d1, blank_d2;
   logic [RGB_W-1:0]  orgb_q;
   logic [PAL_DW-1:0] cpudo_q;
   logic              cpurdy_q;

   // Visible pixels own the RAM; on blank edges a commit beats a pending read
   assign commit = wb_full & bus.BLANK;
   assign rd_acc = (state == RDPEND) & bus.BLANK & ~commit;

   always_comb begin
      ram_we = 1'b0;
      ram_ad = bus.PIDX;
      if (commit) begin
         ram_we = 1'b1;
         ram_ad = wb_ad;
      end else if (rd_acc) begin
         ram_ad = rd_ad;
      end
   end

   sys1_palram #(.AW(PAL_AW), .DW(PAL_DW)) u_ram (
      .clk  (PCLK),
      .we   (ram_we),
      .addr (ram_ad),
      .wdat (wb_di),
      .rdat (ram_q)
   );

   always_ff @(posedge PCLK or posedge RESET) begin
      if (RESET) begin
         wb_full <= 1'b0;
         wb_ad   <= '0;
         wb_di   <= '0;
      end else if (commit) begin
         wb_full <= 1'b0;
      end else if (!wb_full && bus.CPUWR) begin
         wb_full <= 1'b1;
         wb_ad   <= bus.CPUAD;
         wb_di   <= bus.CPUDI;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.CPURD) state_nxt = RDPEND;
         RDPEND:  if (rd_acc)    state_nxt = RDDATA;
         RDDATA:  if (rd_ph)     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // RAM data passes through ram_dq for both paths, giving 2 edges from access to output
   always_ff @(posedge PCLK or posedge RESET) begin
      if (RESET) begin
         state    <= IDLE;
         rd_ph    <= 1'b0;
         rd_ad    <= '0;
         ram_dq   <= '0;
         blank_d1 <= 1'b1;
         blank_d2 <= 1'b1;
         orgb_q   <= '0;
         cpudo_q  <= '0;
         cpurdy_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         rd_ph    <= (state == RDDATA) & ~rd_ph;
         if (state == IDLE && bus.CPURD)
            rd_ad <= bus.CPUAD;
         ram_dq   <= ram_q;
         blank_d1 <= bus.BLANK;
         blank_d2 <= blank_d1;
         orgb_q   <= blank_d2 ? '0 : pal8_to_rgb15(ram_dq);
         cpurdy_q <= (state == RDDATA) & rd_ph;
         if (state == RDDATA && rd_ph)
            cpudo_q <= ram_dq;
      end
   end

   assign bus.ORGB    = orgb_q;
   assign bus.CPUDO   = cpudo_q;
   assign bus.CPURDY  = cpurdy_q;
   assign bus.CPUWAIT = wb_full;
endmodule

// File: tb/tb_sys1_palette.sv
// Directed bench for sys1_palette: a reference RAM/buffer/read model feeds a queue of expected pixels.
module tb_sys1_palette;
   logic PCLK = 1'b0;
   logic RESET = 1'b0;
   sys1_palette_if bus();

   sys1_palette dut (.PCLK(PCLK), .RESET(RESET), .bus(bus));

   always #5 PCLK = ~PCLK;

   typedef struct packed {
      logic        chk;
      logic [14:0] v;
   } exp_t;

   exp_t        q[$];
   logic [7:0]  m_mem [2048];
   logic        known [2048];
   logic        m_full;
   logic [10:0] m_wa;
   logic [7:0]  m_wd;
   int          m_st;
   int          m_cnt;
   logic [10:0] m_ra;
   logic [7:0]  m_rd;
   logic        m_rk;
   int          n_tests = 0;
   int          n_fail = 0;
   logic [10:0] addrs [6] = '{11'h005, 11'h006, 11'h010, 11'h011, 11'h012, 11'h021};

   function automatic logic [14:0] exp15(input logic [7:0] e);
      int r, g, b;
      r = (int'(e[2:0]) << 2) | int'(e[2:1]);
      g = (int'(e[5:3]) << 2) | int'(e[5:4]);
      b = (int'(e[7:6]) << 3) | (int'(e[7:6]) << 1) | int'(e[7]);
      return 15'((b << 10) | (g << 5) | r);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_full = 1'b0;
      m_st   = 0;
      m_cnt  = 0;
      q.delete();
   endtask

   task automatic tick(input logic [10:0] pidx, input logic blank, input logic wr,
                       input logic [10:0] ad, input logic [7:0] di, input logic rd);
      exp_t e;
      logic commit, exp_rdy;
      bus.PIDX  = pidx;
      bus.BLANK = blank;
      bus.CPUWR = wr;
      bus.CPUAD = ad;
      bus.CPUDI = di;
      bus.CPURD = rd;
      @(posedge PCLK);
      e.chk = blank | known[pidx];
      e.v   = blank ? 15'd0 : exp15(m_mem[pidx]);
      q.push_back(e);
      commit  = m_full & blank;
      exp_rdy = 1'b0;
      if (m_cnt != 0) begin
         m_cnt--;
         if (m_cnt == 0) begin
            exp_rdy = 1'b1;
            m_st    = 0;
         end
      end else if (m_st == 0 && rd) begin
         m_st = 1;
         m_ra = ad;
      end else if (m_st == 1 && blank && !commit) begin
         m_st  = 2;
         m_cnt = 2;
         m_rd  = m_mem[m_ra];
         m_rk  = known[m_ra];
      end
      if (commit) begin
         m_mem[m_wa] = m_wd;
         known[m_wa] = 1'b1;
         m_full      = 1'b0;
      end else if (!m_full && wr) begin
         m_full = 1'b1;
         m_wa   = ad;
         m_wd   = di;
      end
      #1;
      chk("cpuwait", 32'(bus.CPUWAIT), 32'(m_full));
      chk("cpurdy", 32'(bus.CPURDY), 32'(exp_rdy));
      if (exp_rdy && m_rk)
         chk("cpudo", 32'(bus.CPUDO), 32'(m_rd));
      if (q.size() == 3) begin
         e = q.pop_front();
         if (e.chk)
            chk("orgb", 32'(bus.ORGB), 32'(e.v));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 2048; i++) begin
         known[i] = 1'b0;
         m_mem[i] = 8'h00;
      end
      model_reset();
      bus.PIDX = '0; bus.BLANK = 1'b1; bus.CPUWR = 1'b0;
      bus.CPUAD = '0; bus.CPUDI = '0; bus.CPURD = 1'b0;

      // Reset values
      #1 RESET = 1'b1;
      #2;
      chk("rst_orgb", 32'(bus.ORGB), 32'h0);
      chk("rst_cpudo", 32'(bus.CPUDO), 32'h0);
      chk("rst_cpurdy", 32'(bus.CPURDY), 32'h0);
      chk("rst_cpuwait", 32'(bus.CPUWAIT), 32'h0);
      @(posedge PCLK);
      @(posedge PCLK);
      #1 RESET = 1'b0;

      // Initial palette entries, written during blank
      tick(0, 1, 1, 11'h005, 8'hFF, 0); tick(0, 1, 0, 0, 0, 0);
      tick(0, 1, 1, 11'h006, 8'h49, 0); tick(0, 1, 0, 0, 0, 0);
      tick(0, 1, 1, 11'h010, 8'hC0, 0); tick(0, 1, 0, 0, 0, 0);
      tick(0, 1, 1, 11'h011, 8'h38, 0); tick(0, 1, 0, 0, 0, 0);
      tick(0, 1, 1, 11'h012, 8'h24, 0); tick(0, 1, 0, 0, 0, 0);
      tick(0, 1, 1, 11'h030, 8'h01, 0); tick(0, 1, 0, 0, 0, 0);

      // Colour expansion
      tick(11'h005, 0, 0, 0, 0, 0);
      tick(11'h006, 0, 0, 0, 0, 0);
      tick(11'h010, 0, 0, 0, 0, 0);
      tick(11'h011, 0, 0, 0, 0, 0);
      tick(11'h012, 0, 0, 0, 0, 0);
      tick(0, 1, 0, 0, 0, 0); tick(0, 1, 0, 0, 0, 0);

      // Deferred write over a 50-cycle visible run, plus a dropped write to 0x11
      tick(11'h010, 0, 1, 11'h010, 8'h07, 0);
      tick(11'h010, 0, 1, 11'h011, 8'hC0, 0);
      for (int i = 0; i < 48; i++)
         tick(11'h010, 0, 0, 0, 0, 0);
      // Commit edge; a write on this edge is dropped
      tick(0, 1, 1, 11'h012, 8'h99, 0);
      tick(11'h010, 0, 0, 0, 0, 0);
      tick(11'h011, 0, 0, 0, 0, 0);
      tick(11'h012, 0, 0, 0, 0, 0);
      tick(0, 1, 0, 0, 0, 0); tick(0, 1, 0, 0, 0, 0);

      // Read arbitration: buffered write and pending read share one blank run
      tick(11'h005, 0, 1, 11'h020, 8'h5A, 0);
      tick(11'h006, 0, 0, 11'h020, 8'h00, 1);
      for (int i = 0; i < 6; i++)
         tick(0, 1, 0, 0, 0, 0);
      // Read with no pending commit: shortest CPURD to CPURDY
      tick(0, 1, 0, 11'h005, 8'h00, 1);
      for (int i = 0; i < 4; i++)
         tick(0, 1, 0, 0, 0, 0);

      // Random blanking, a commit lands inside it
      for (int i = 0; i < 40; i++)
         tick(addrs[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
              (i == 3), 11'h021, 8'h66, 0);
      tick(11'h021, 0, 0, 0, 0, 0);
      tick(0, 1, 0, 0, 0, 0); tick(0, 1, 0, 0, 0, 0);

      // Reset while a read is pending and the buffer is full
      tick(11'h005, 0, 1, 11'h030, 8'hEE, 0);
      tick(11'h005, 0, 0, 11'h005, 8'h00, 1);
      #3 RESET = 1'b1;
      #1;
      chk("mid_rst_cpuwait", 32'(bus.CPUWAIT), 32'h0);
      chk("mid_rst_cpurdy", 32'(bus.CPURDY), 32'h0);
      chk("mid_rst_orgb", 32'(bus.ORGB), 32'h0);
      model_reset();
      @(posedge PCLK);
      @(posedge PCLK);
      #1 RESET = 1'b0;
      for (int i = 0; i < 8; i++)
         tick(0, 1, 0, 0, 0, 0);
      tick(11'h030, 0, 0, 0, 0, 0);
      tick(11'h005, 0, 0, 0, 0, 0);
      tick(11'h010, 0, 0, 0, 0, 0);
      tick(0, 1, 0, 0, 0, 0); tick(0, 1, 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
